// File: rtl/sdrc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdrc_arb_pkg
// Description : Shared types and default constants for the two-master
//               Wishbone arbiter in front of the SDRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sdrc_arb_pkg;

    // Default parameter values for the arbiter
    localparam int c_APP_AW   = 26;
    localparam int c_DW       = 32;
    localparam int c_MAX_HOLD = 16;

    // Arbiter states; HANDOFF is the single dead cycle between grants
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT0    = 2'd1,
        GNT1    = 2'd2,
        HANDOFF = 2'd3
    } arb_state_t;

endpackage : sdrc_arb_pkg
`default_nettype wire

// File: rtl/sdrc_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdrc_wb_arb
// Description : Round-robin arbiter sharing one SDRAM-controller Wishbone
//               slave between two masters. A master holding the grant can be
//               preempted after MAX_HOLD acks when the other master waits.
// Revision    : 1.0 - initial release
// ============================================================================
module sdrc_wb_arb
    import sdrc_arb_pkg::*;
#(
    parameter int APP_AW   = c_APP_AW,
    parameter int DW       = c_DW,
    parameter int MAX_HOLD = c_MAX_HOLD
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // master 0
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [APP_AW-1:0] m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    // master 1
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [APP_AW-1:0] m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    // shared slave side
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [APP_AW-1:0] s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);

    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_t state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // 0 = m0 granted last, 1 = m1
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic w_req0, w_req1;
    logic w_own_cyc, w_own_ack, w_other_req, w_hold_hit;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;

    // Read data goes to both masters; only the ack qualifies it
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Request mux: route the granted master to the slave, gate everything otherwise
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        gnt_o    = 2'b00;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                gnt_o    = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

    // Next-state, round-robin bookkeeping and hold counter
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        hold_cnt_d  = hold_cnt_q;
        w_own_cyc   = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
        w_own_ack   = m0_ack_o | m1_ack_o;
        w_other_req = (state_q == GNT1) ? w_req0 : w_req1;
        // True when the ack being forwarded now reaches the hold limit
        w_hold_hit  = ({1'b0, hold_cnt_q} + 9'd1) >= {1'b0, c_HOLD_LIMIT};
        case (state_q)
            IDLE, HANDOFF: begin
                // last_gnt tracks every grant so a master just served loses
                // the next contention, which is what lets a preempted master back in
                if (w_req0 && w_req1) begin
                    state_d    = last_gnt_q ? GNT0 : GNT1;
                    last_gnt_d = ~last_gnt_q;
                    hold_cnt_d = 8'd0;
                end else if (w_req0) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                    hold_cnt_d = 8'd0;
                end else if (w_req1) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                    hold_cnt_d = 8'd0;
                end else begin
                    state_d    = IDLE;
                end
            end
            default: begin
                if (w_own_ack && (hold_cnt_q < c_HOLD_LIMIT)) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                if (!w_own_cyc) begin
                    state_d = HANDOFF;
                end else if (w_own_ack && w_hold_hit && w_other_req) begin
                    state_d = HANDOFF;
                end
            end
        endcase
    end

    // State registers with synchronous reset; m0 wins the first contention
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule : sdrc_wb_arb
`default_nettype wire

// File: tb/tb_sdrc_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdrc_wb_arb
// Description : Self-checking bench for sdrc_wb_arb: a cycle table for the
//               arbitration core plus burst sequences against a small slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdrc_wb_arb;
    import sdrc_arb_pkg::*;

    localparam int AW = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mc [2];
    logic          ms [2];
    logic          mw [2];
    logic [AW-1:0] ma [2];
    logic [DW-1:0] md [2];

    // instance A (MAX_HOLD=4) outputs and slave
    logic [DW-1:0] a_dat0, a_dat1, s_dato, s_dati;
    logic          a_ack0, a_ack1, s_cyc, s_stb, s_we, s_ack;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_adr;
    logic [1:0]    a_gnt;
    // instance B (MAX_HOLD=16) outputs and slave
    logic [DW-1:0] b_dat0, b_dat1, b_s_dato, b_s_dati;
    logic          b_ack0, b_ack1, b_s_cyc, b_s_stb, b_s_we, b_s_ack;
    logic [3:0]    b_s_sel;
    logic [AW-1:0] b_s_adr;
    logic [1:0]    b_gnt;

    logic          auto_ack, force_ack, sel16;
    logic [DW-1:0] mem [256];

    assign s_ack    = force_ack | (auto_ack & s_cyc & s_stb);
    assign s_dati   = mem[s_adr[7:0]];
    assign b_s_ack  = auto_ack & b_s_cyc & b_s_stb;
    assign b_s_dati = '0;

    always @(posedge clk) begin
        if (s_cyc && s_stb && s_we && s_ack) mem[s_adr[7:0]] <= s_dato;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    sdrc_wb_arb #(.APP_AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(4'hF),
        .m0_adr_i(ma[0]), .m0_dat_i(md[0]), .m0_dat_o(a_dat0), .m0_ack_o(a_ack0),
        .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(4'hF),
        .m1_adr_i(ma[1]), .m1_dat_i(md[1]), .m1_dat_o(a_dat1), .m1_ack_o(a_ack1),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dato), .s_dat_i(s_dati), .s_ack_i(s_ack),
        .gnt_o(a_gnt)
    );

    sdrc_wb_arb #(.APP_AW(AW), .DW(DW), .MAX_HOLD(16)) dut16 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(4'hF),
        .m0_adr_i(ma[0]), .m0_dat_i(md[0]), .m0_dat_o(b_dat0), .m0_ack_o(b_ack0),
        .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(4'hF),
        .m1_adr_i(ma[1]), .m1_dat_i(md[1]), .m1_dat_o(b_dat1), .m1_ack_o(b_ack1),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
        .s_adr_o(b_s_adr), .s_dat_o(b_s_dato), .s_dat_i(b_s_dati), .s_ack_i(b_s_ack),
        .gnt_o(b_gnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] wdat(input int m, input logic [AW-1:0] a);
        return {8'hA5, 4'(m), 4'h0, a[15:0]};
    endfunction

    int            q_cyc0 [$];
    int            q_cyc1 [$];
    logic [AW-1:0] q_adr0 [$];
    logic [AW-1:0] q_adr1 [$];

    task automatic clear_logs();
        q_cyc0.delete(); q_cyc1.delete(); q_adr0.delete(); q_adr1.delete();
    endtask

    // Reset over one edge; returns one time unit after the releasing edge
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 1'b0; ms[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; md[i] = '0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Classic Wishbone burst: hold cyc/stb, advance address on each ack
    task automatic burst(input int m, input logic we, input logic [AW-1:0] a0, input int n);
        int            got    = 0;
        int            budget = 200;
        logic [AW-1:0] a      = a0;
        logic          ackd;
        mc[m] = 1'b1; ms[m] = 1'b1; mw[m] = we; ma[m] = a; md[m] = wdat(m, a);
        while (got < n && budget > 0) begin
            @(negedge clk);
            if (m == 0) ackd = sel16 ? b_ack0 : a_ack0;
            else        ackd = sel16 ? b_ack1 : a_ack1;
            if (ackd) begin
                if (m == 0) begin
                    q_cyc0.push_back(cyc_cnt);
                    q_adr0.push_back(sel16 ? b_s_adr : s_adr);
                end else begin
                    q_cyc1.push_back(cyc_cnt);
                    q_adr1.push_back(sel16 ? b_s_adr : s_adr);
                end
                check("gnt_at_ack", 64'(sel16 ? b_gnt : a_gnt), (m == 0) ? 64'd1 : 64'd2);
                if (!we) check("rd_data", 64'((m == 0) ? a_dat0 : a_dat1), 64'(wdat(m, a)));
                got++;
                a = a + 1'b1;
            end
            budget--;
            @(posedge clk); #1;
            ma[m] = a; md[m] = wdat(m, a);
        end
        if (got < n) check("burst_timeout_acks", 64'(got), 64'(n));
        mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0;
    endtask

    // Cycle table: inputs {c0,s0,c1,s1,ack}, expected {gnt[1:0],s_cyc,ack0,ack1}
    typedef struct packed {
        logic [4:0] in;
        logic [4:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int t0;
        logic [AW-1:0] exp_adr;
        rst = 1'b1; auto_ack = 1'b0; force_ack = 1'b0; sel16 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 1'b0; ms[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; md[i] = '0;
        end

        //               c0 s0 c1 s1 ack    gnt s_cyc a0 a1
        tbl[0]  = {5'b00001, 5'b00_0_0_0};  // IDLE, stray ack dropped
        tbl[1]  = {5'b11110, 5'b00_0_0_0};  // contention, m0 wins first
        tbl[2]  = {5'b11111, 5'b01_1_1_0};
        tbl[3]  = {5'b11110, 5'b01_1_0_0};
        tbl[4]  = {5'b00110, 5'b01_0_0_0};  // m0 drops cyc
        tbl[5]  = {5'b00111, 5'b00_0_0_0};  // HANDOFF, stray ack dropped
        tbl[6]  = {5'b00111, 5'b10_1_0_1};
        tbl[7]  = {5'b11111, 5'b10_1_0_1};
        tbl[8]  = {5'b11111, 5'b10_1_0_1};
        tbl[9]  = {5'b11111, 5'b10_1_0_1};  // 4th ack with m0 waiting: preempt
        tbl[10] = {5'b11111, 5'b00_0_0_0};  // HANDOFF, round-robin to m0
        tbl[11] = {5'b11110, 5'b01_1_0_0};
        tbl[12] = {5'b00001, 5'b01_0_0_0};  // stb low: ack not forwarded
        tbl[13] = {5'b00001, 5'b00_0_0_0};
        tbl[14] = {5'b11000, 5'b00_0_0_0};
        tbl[15] = {5'b01001, 5'b01_0_1_0};  // ack while cyc falls: forwarded
        tbl[16] = {5'b00001, 5'b00_0_0_0};
        tbl[17] = {5'b00110, 5'b00_0_0_0};
        tbl[18] = {5'b00111, 5'b10_1_0_1};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        check("reset_outputs", {a_gnt, s_cyc, s_stb, a_ack0, a_ack1}, 6'd0);
        check("reset_state", dut.state_q, IDLE);
        check("reset_hold", dut.hold_cnt_q, 8'd0);

        // ---- cycle table ----
        do_reset();
        for (int i = 0; i < NV; i++) begin
            {mc[0], ms[0], mc[1], ms[1], force_ack} = tbl[i].in;
            ma[0] = 26'h111; ma[1] = 26'h222;
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), {a_gnt, s_cyc, a_ack0, a_ack1}, tbl[i].exp);
            exp_adr = (tbl[i].exp[4:3] == 2'b01) ? 26'h111 :
                      (tbl[i].exp[4:3] == 2'b10) ? 26'h222 : 26'h0;
            check($sformatf("tbl_adr[%0d]", i), s_adr, exp_adr);
            @(posedge clk); #1;
        end
        force_ack = 1'b0;

        // ---- m0 alone writes 4 words ----
        auto_ack = 1'b1;
        do_reset();
        clear_logs();
        t0 = cyc_cnt;
        burst(0, 1'b1, 26'h10000, 4);
        check("m0_only_ack_count", q_cyc0.size(), 4);
        for (int i = 0; i < q_cyc0.size(); i++) begin
            check($sformatf("m0_only_ack_cyc[%0d]", i), q_cyc0[i] - t0, i + 1);
            check($sformatf("m0_only_adr[%0d]", i), q_adr0[i], 26'h10000 + i);
        end
        @(negedge clk);
        check("m0_only_cyc_dropped", {a_gnt, s_cyc}, 3'b01_0);
        @(posedge clk); #1;
        @(negedge clk);
        check("m0_only_handoff", dut.state_q, HANDOFF);
        check("m0_only_handoff_out", {a_gnt, s_cyc, s_stb}, 4'd0);
        @(posedge clk); #1;

        // ---- simultaneous requests, then read back ----
        do_reset();
        clear_logs();
        fork
            burst(0, 1'b1, 26'h20, 3);
            burst(1, 1'b1, 26'h40, 3);
        join
        check("both_m0_first", (q_cyc0.size() == 3 && q_cyc1.size() == 3 &&
                                q_cyc0[2] < q_cyc1[0]), 1'b1);
        if (q_cyc0.size() == 3 && q_cyc1.size() == 3)
            check("both_dead_gap", q_cyc1[0] - q_cyc0[2], 3);
        repeat (3) begin @(posedge clk); #1; end
        fork
            burst(0, 1'b0, 26'h20, 3);
            burst(1, 1'b0, 26'h40, 3);
        join
        repeat (3) begin @(posedge clk); #1; end

        // ---- preemption with MAX_HOLD=4 ----
        do_reset();
        clear_logs();
        t0 = cyc_cnt;
        fork
            burst(0, 1'b1, 26'h80, 10);
            burst(1, 1'b1, 26'hC0, 2);
        join
        check("pre_m0_count", q_cyc0.size(), 10);
        check("pre_m1_count", q_cyc1.size(), 2);
        for (int i = 0; i < q_cyc0.size() && i < 10; i++) begin
            check($sformatf("pre_m0_cyc[%0d]", i), q_cyc0[i] - t0, (i < 4) ? i + 1 : i + 6);
            check($sformatf("pre_m0_adr[%0d]", i), q_adr0[i], 26'h80 + i);
        end
        for (int i = 0; i < q_cyc1.size() && i < 2; i++) begin
            check($sformatf("pre_m1_cyc[%0d]", i), q_cyc1[i] - t0, i + 6);
        end
        repeat (3) begin @(posedge clk); #1; end

        // ---- long single-master burst with MAX_HOLD=16 ----
        sel16 = 1'b1;
        do_reset();
        clear_logs();
        t0 = cyc_cnt;
        burst(1, 1'b1, 26'h0, 20);
        check("long_count", q_cyc1.size(), 20);
        if (q_cyc1.size() == 20) begin
            check("long_first", q_cyc1[0] - t0, 1);
            check("long_no_gap", q_cyc1[19] - q_cyc1[0], 19);
        end
        check("long_hold_sat", dut16.hold_cnt_q, 8'd16);
        check("long_gnt", b_gnt, 2'b10);
        sel16 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // ---- reset in the middle of an m1 burst ----
        do_reset();
        mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b0; ma[1] = 26'h40;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_granted", a_gnt, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mc[0] = 1'b1; ms[0] = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", {a_gnt, s_cyc, s_stb, a_ack0, a_ack1}, 6'd0);
        check("mid_rst_adr", s_adr, 26'h0);
        check("mid_rst_state", dut.state_q, IDLE);
        force_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_m0_wins", a_gnt, 2'b01);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin mc[i] = 1'b0; ms[i] = 1'b0; end
        repeat (3) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sdrc_wb_arb
`default_nettype wire
